// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
//   Streams a program into a 1024-word instruction/data memory from an 8-bit
//   byte stream (MSB of each word first), then releases the processor.
//   While loading it counts words carrying an unsupported opcode and flags
//   whether a halt opcode (6'b111111) was seen.
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for start, processor held
//   COLLECT  | accepting bytes into the word register (in_ready = 1)
//   WRITE    | one-cycle memory write of the assembled word
//   DONE     | load complete, processor released (cpu_run = 1)
//
// Ports
//   clk1, rst_n        : clock, synchronous active-low reset
//   start              : load request, honoured in IDLE or DONE only
//   base_addr,word_cnt : load window, sampled when start is honoured
//   abort              : cancels a load in COLLECT/WRITE
//   in_valid,in_data   : byte stream in; in_ready : byte stream ready
//   mem_we,mem_addr,
//   mem_wdata          : memory write port (one strobe per word)
//   busy, done, cpu_run: status
//   illegal_cnt        : saturating count of unsupported-opcode words
//   hlt_seen           : a loaded word had opcode 63
// -----------------------------------------------------------------------------
module prog_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 11
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_cnt,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              cpu_run,
    output logic [7:0]        illegal_cnt,
    output logic              hlt_seen
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_base;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_widx;
    logic [1:0]        r_bidx;
    logic [31:0]       r_word;
    logic [7:0]        r_illegal;
    logic              r_hlt;

    logic [CNT_W-1:0]  w_widx_next;
    logic [5:0]        w_opcode;
    logic              w_op_supported;
    logic              w_op_halt;

    assign w_widx_next    = r_widx + CNT_W'(1);
    assign w_opcode       = r_word[31:26];
    assign w_op_halt      = (w_opcode == 6'd63);
    assign w_op_supported = (w_opcode <= 6'd5)
                          || ((w_opcode >= 6'd8) && (w_opcode <= 6'd14))
                          || w_op_halt;

    assign in_ready    = (r_state == S_COLLECT);
    // An abort landing in the WRITE cycle must kill the strobe that same cycle.
    assign mem_we      = (r_state == S_WRITE) && !abort;
    // Address arithmetic is ADDR_W wide so the window wraps 1023 -> 0.
    assign mem_addr    = r_base + ADDR_W'(r_widx);
    assign mem_wdata   = r_word;
    assign busy        = (r_state == S_COLLECT) || (r_state == S_WRITE);
    assign done        = (r_state == S_DONE);
    assign cpu_run     = (r_state == S_DONE);
    assign illegal_cnt = r_illegal;
    assign hlt_seen    = r_hlt;

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_base    <= '0;
            r_cnt     <= '0;
            r_widx    <= '0;
            r_bidx    <= '0;
            r_word    <= '0;
            r_illegal <= '0;
            r_hlt     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_base    <= base_addr;
                        r_cnt     <= word_cnt;
                        r_widx    <= '0;
                        r_bidx    <= '0;
                        r_illegal <= '0;
                        r_hlt     <= 1'b0;
                        r_state   <= (word_cnt != '0) ? S_COLLECT : S_DONE;
                    end
                end
                S_COLLECT: begin
                    if (abort) begin
                        r_bidx  <= '0;
                        r_state <= S_IDLE;
                    end else if (in_valid) begin
                        r_word <= {r_word[23:0], in_data};
                        r_bidx <= r_bidx + 2'd1;
                        if (r_bidx == 2'd3) begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    if (abort) begin
                        r_bidx  <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_widx <= w_widx_next;
                        r_bidx <= '0;
                        if (!w_op_supported && (r_illegal != 8'hFF)) begin
                            r_illegal <= r_illegal + 8'd1;
                        end
                        if (w_op_halt) begin
                            r_hlt <= 1'b1;
                        end
                        r_state <= (w_widx_next == r_cnt) ? S_DONE : S_COLLECT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// -----------------------------------------------------------------------------
// tb_prog_loader
//   Self-checking bench for prog_loader. Writes seen on the memory port are
//   captured into queues and compared against an expected list built from the
//   loaded words (address = base + index mod 1024, opcode classification by
//   plain arithmetic on the word list).
// -----------------------------------------------------------------------------
module tb_prog_loader;
    localparam int ADDR_W = 10;
    localparam int CNT_W  = 11;

    logic              clk1 = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  word_cnt;
    logic              abort;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              busy;
    logic              done;
    logic              cpu_run;
    logic [7:0]        illegal_cnt;
    logic              hlt_seen;

    prog_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk1(clk1), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .word_cnt(word_cnt), .abort(abort), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .busy(busy), .done(done),
        .cpu_run(cpu_run), .illegal_cnt(illegal_cnt), .hlt_seen(hlt_seen)
    );

    always #5 clk1 = ~clk1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int acc_cnt  = 0;

    logic [ADDR_W-1:0] wq_addr[$];
    logic [31:0]       wq_data[$];
    logic [7:0]        tx_bytes[$];

    always @(posedge clk1) cyc <= cyc + 1;

    // Capture every write; a word may only be written once all four of its
    // bytes have been accepted.
    always @(negedge clk1) begin
        if (mem_we) begin
            n_checks++;
            if (acc_cnt != 4 * (wq_addr.size() + 1)) begin
                n_errors++;
                $display("FAIL write_timing: bytes accepted %0d, required %0d",
                         acc_cnt, 4 * (wq_addr.size() + 1));
            end
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic do_start(input int base, input int cnt);
        base_addr = ADDR_W'(base);
        word_cnt  = CNT_W'(cnt);
        start     = 1'b1;
        step();
        start     = 1'b0;
    endtask

    task automatic clear_capture();
        wq_addr.delete();
        wq_data.delete();
        tx_bytes.delete();
        acc_cnt = 0;
    endtask

    task automatic push_word(input logic [31:0] w);
        tx_bytes.push_back(w[31:24]);
        tx_bytes.push_back(w[23:16]);
        tx_bytes.push_back(w[15:8]);
        tx_bytes.push_back(w[7:0]);
    endtask

    // Sends every byte in tx_bytes (then empties it); rnd gaps in_valid.
    task automatic stream(input bit rnd, output int first_acc);
        int idx = 0;
        int budget = 0;
        first_acc = -1;
        while (idx < tx_bytes.size() && budget < 20000) begin
            in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = tx_bytes[idx];
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                idx++;
                acc_cnt++;
            end
            step();
            budget++;
        end
        in_valid = 1'b0;
        if (idx < tx_bytes.size()) chk("stream_timeout", 64'(idx), 64'(tx_bytes.size()));
        tx_bytes.delete();
    endtask

    task automatic wait_done(output int done_cyc);
        int budget = 0;
        while (!done && budget < 200) begin
            step();
            budget++;
        end
        done_cyc = cyc;
        chk("done_timeout", done, 1'b1);
    endtask

    function automatic bit op_illegal(input logic [31:0] w);
        int op = int'(w[31:26]);
        return !((op <= 5) || (op >= 8 && op <= 14) || op == 63);
    endfunction

    task automatic check_load(input string tag, input int base, input logic [31:0] words[$]);
        int ill = 0;
        bit hlt = 1'b0;
        chk({tag, "_nwrites"}, 64'(wq_addr.size()), 64'(words.size()));
        foreach (words[i]) begin
            if (op_illegal(words[i])) ill++;
            if (words[i][31:26] == 6'h3F) hlt = 1'b1;
            if (i < wq_addr.size()) begin
                chk({tag, "_addr"}, 64'(wq_addr[i]), 64'((base + i) % (1 << ADDR_W)));
                chk({tag, "_data"}, 64'(wq_data[i]), 64'(words[i]));
            end
        end
        chk({tag, "_illegal"}, 64'(illegal_cnt), 64'((ill > 255) ? 255 : ill));
        chk({tag, "_hlt"}, 64'(hlt_seen), 64'(hlt));
        chk({tag, "_status"}, {busy, done, cpu_run}, 3'b011);
    endtask

    task automatic run_load(input string tag, input int base, input logic [31:0] words[$],
                            input bit rnd, output int first_acc, output int done_cyc);
        clear_capture();
        foreach (words[i]) push_word(words[i]);
        do_start(base, words.size());
        stream(rnd, first_acc);
        wait_done(done_cyc);
        check_load(tag, base, words);
    endtask

    typedef struct {
        logic [31:0] word;
        logic [7:0]  exp_ill;
        logic        exp_hlt;
    } vec_t;

    vec_t vecs[11];

    initial begin
        logic [31:0] words[$];
        int fa, dc;

        vecs[0]  = '{32'h2801000A, 8'd0, 1'b0};
        vecs[1]  = '{32'hFC000000, 8'd0, 1'b1};
        vecs[2]  = '{32'h18000000, 8'd1, 1'b0};
        vecs[3]  = '{32'h1C000000, 8'd1, 1'b0};
        vecs[4]  = '{32'h14000000, 8'd0, 1'b0};
        vecs[5]  = '{32'h20000000, 8'd0, 1'b0};
        vecs[6]  = '{32'h38000000, 8'd0, 1'b0};
        vecs[7]  = '{32'h3C000000, 8'd1, 1'b0};
        vecs[8]  = '{32'hF8000000, 8'd1, 1'b0};
        vecs[9]  = '{32'h00000000, 8'd0, 1'b0};
        vecs[10] = '{32'h24ABCDEF, 8'd0, 1'b0};

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
        in_data = '0; base_addr = '0; word_cnt = '0;
        repeat (3) step();
        chk("reset_outputs", {in_ready, mem_we, busy, done, cpu_run, illegal_cnt, hlt_seen}, '0);
        rst_n = 1'b1;
        step();
        chk("idle_after_reset", {busy, done, cpu_run, in_ready}, 4'b0000);

        // Reference two-word load, back-to-back bytes.
        words = '{32'h2801000A, 32'hFC000000};
        run_load("b2b", 0, words, 1'b0, fa, dc);
        chk("b2b_w0", 64'(wq_data.size() > 0 ? wq_data[0] : 32'h0), 64'h2801000A);
        chk("b2b_w1", 64'(wq_data.size() > 1 ? wq_data[1] : 32'h0), 64'hFC000000);
        chk("b2b_latency", 64'(dc - fa), 64'd10);

        // Same words with in_valid gapped: identical writes, only later.
        run_load("gapped", 0, words, 1'b1, fa, dc);

        // Address wrap at the top of memory.
        words = '{$urandom(), $urandom()};
        run_load("wrap", 1023, words, 1'b0, fa, dc);

        // Opcode classification, one word per load.
        for (int i = 0; i < 11; i++) begin
            clear_capture();
            push_word(vecs[i].word);
            do_start(i * 7, 1);
            stream(1'b0, fa);
            wait_done(dc);
            chk("vec_nwrites", 64'(wq_data.size()), 64'd1);
            chk("vec_data", 64'(wq_data.size() > 0 ? wq_data[0] : 32'h0), 64'(vecs[i].word));
            chk("vec_illegal", 64'(illegal_cnt), 64'(vecs[i].exp_ill));
            chk("vec_hlt", 64'(hlt_seen), 64'(vecs[i].exp_hlt));
        end

        // 300 unsupported-opcode words saturate the counter.
        words.delete();
        for (int i = 0; i < 300; i++) begin
            logic [5:0] op;
            op = $urandom_range(0, 1) ? 6'($urandom_range(6, 7)) : 6'($urandom_range(15, 62));
            words.push_back({op, 26'($urandom())});
        end
        run_load("sat", 500, words, 1'b0, fa, dc);
        chk("sat_255", 64'(illegal_cnt), 64'd255);

        // Reset while in DONE with nonzero status.
        rst_n = 1'b0;
        step();
        chk("reset_from_done", {in_ready, mem_we, busy, done, cpu_run, illegal_cnt, hlt_seen}, '0);
        rst_n = 1'b1;
        step();

        // Randomized loads against the word-list model.
        for (int t = 0; t < 6; t++) begin
            words.delete();
            for (int i = 0; i < $urandom_range(1, 6); i++) words.push_back($urandom());
            run_load("rand", $urandom_range(0, 1023), words, 1'($urandom_range(0, 1)), fa, dc);
        end

        // start during a load is ignored.
        clear_capture();
        words = '{32'h0400_1111, 32'h0800_2222};
        do_start(40, 2);
        push_word(words[0]);
        tx_bytes = '{tx_bytes[0], tx_bytes[1]};
        stream(1'b0, fa);
        base_addr = 10'd600; word_cnt = 11'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("start_ignored_busy", busy, 1'b1);
        tx_bytes = '{8'h11, 8'h11};
        push_word(words[1]);
        stream(1'b0, fa);
        wait_done(dc);
        check_load("busy_start", 40, words);

        // Abort after six bytes of a three-word load.
        clear_capture();
        words = '{32'h0C11_2233, 32'h1055_6677, 32'h2899_AABB};
        do_start(100, 3);
        push_word(words[0]);
        tx_bytes.push_back(words[1][31:24]);
        tx_bytes.push_back(words[1][23:16]);
        stream(1'b0, fa);
        chk("abort_pre_busy", busy, 1'b1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_idle", {busy, done, cpu_run, in_ready}, 4'b0000);
        in_valid = 1'b1;
        repeat (6) step();
        in_valid = 1'b0;
        chk("abort_nwrites", 64'(wq_addr.size()), 64'd1);
        chk("abort_addr", 64'(wq_addr.size() > 0 ? wq_addr[0] : 10'd0), 64'd100);
        chk("abort_data", 64'(wq_data.size() > 0 ? wq_data[0] : 32'h0), 64'h0C112233);

        // Abort landing in the WRITE cycle suppresses the strobe.
        clear_capture();
        do_start(200, 2);
        push_word(32'h0000_0001);
        stream(1'b0, fa);
        chk("write_state", {busy, in_ready}, 2'b10);
        abort = 1'b1;
        #1;
        chk("abort_write_we", mem_we, 1'b0);
        step();
        abort = 1'b0;
        chk("abort_write_idle", busy, 1'b0);
        chk("abort_write_nwrites", 64'(wq_addr.size()), 64'd0);

        // start + abort together: start wins when idle, abort wins when busy.
        start = 1'b1; abort = 1'b1; base_addr = 10'd5; word_cnt = 11'd1;
        step();
        chk("start_wins_idle", busy, 1'b1);
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_wins_busy", busy, 1'b0);

        // Reset during COLLECT, then an empty load.
        clear_capture();
        do_start(0, 2);
        tx_bytes = '{8'hAA, 8'hBB};
        stream(1'b0, fa);
        rst_n = 1'b0;
        step();
        chk("reset_mid_load", {in_ready, mem_we, busy, done, cpu_run, illegal_cnt, hlt_seen}, '0);
        rst_n = 1'b1;
        step();
        do_start(0, 0);
        chk("zero_cnt_done", {done, cpu_run, busy}, 3'b110);
        step();
        chk("zero_cnt_nwrites", 64'(wq_addr.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning word-address width of the target 1024-word memory.
REQ-002 SHALL have parameter CNT_W, default 11, meaning width of the word-count input (0..1024 words).
REQ-003 SHALL have port clk1  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous to clk1 and active-low.
REQ-005 SHALL have port start  input  1  one-cycle load request; honoured only in IDLE or DONE.
REQ-006 SHALL have port base_addr  input  ADDR_W  first word address; sampled when start is honoured.
REQ-007 SHALL have port word_cnt  input  CNT_W  number of 32-bit words to load; sampled when start is honoured.
REQ-008 SHALL have port abort  input  1  cancels an in-progress load.
REQ-009 SHALL have port in_valid  input  1  byte-stream valid.
REQ-010 SHALL have port in_data  input  8  byte-stream data, most significant byte of each word first.
REQ-011 SHALL have port in_ready  output  1  byte-stream ready; a byte transfers when in_valid and in_ready are both 1.
REQ-012 SHALL have port mem_we  output  1  one-cycle write strobe to instruction/data memory.
REQ-013 SHALL have port mem_addr  output  ADDR_W  write word address.
REQ-014 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-015 SHALL have port busy  output  1  high in COLLECT and WRITE.
REQ-016 SHALL have port done  output  1  high while in DONE.
REQ-017 SHALL have port cpu_run  output  1  processor release; high while in DONE, low otherwise.
REQ-018 SHALL have port illegal_cnt  output  8  saturating count of loaded words with an unsupported opcode.
REQ-019 SHALL have port hlt_seen  output  1  set when any loaded word has opcode 6'b111111.

Function
REQ-020 SHALL implement states IDLE, COLLECT, WRITE, DONE.
REQ-021 IDLE/DONE + start: SHALL latch base_addr and word_cnt, clear word index, byte index, illegal_cnt and hlt_seen; enter COLLECT if word_cnt != 0, else enter DONE (next cycle) with no writes.
REQ-022 start in COLLECT or WRITE SHALL be ignored.
REQ-023 COLLECT: in_ready=1; each accepted byte SHALL shift into the word register (first byte -> bits 31:24, fourth -> bits 7:0); the fourth accepted byte SHALL move the FSM to WRITE.
REQ-024 in_valid low in COLLECT SHALL stall with no state change; there is no timeout.
REQ-025 WRITE lasts exactly one cycle: mem_we=1, mem_addr=(latched base + word index) mod 2^ADDR_W (wraps 1023->0), mem_wdata=assembled word, in_ready=0.
REQ-026 WRITE SHALL increment word index; if the new index equals latched word_cnt enter DONE, else return to COLLECT with byte index 0.
REQ-027 In WRITE, opcode = mem_wdata[31:26]; values 0-5, 8-14, 63 are supported; any other value SHALL increment illegal_cnt, saturating at 255.
REQ-028 In WRITE, opcode 63 SHALL set hlt_seen; it stays set until the next honoured start or reset.
REQ-029 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata are don't-care when mem_we=0.
REQ-030 abort in COLLECT or WRITE SHALL return the FSM to IDLE next cycle, discard any partial word, and suppress mem_we in that cycle if in WRITE; abort in IDLE/DONE SHALL be ignored.
REQ-031 abort and start in the same cycle: abort wins if busy, start wins if idle/done.
REQ-032 Throughput: a load of N words SHALL take 5N cycles from first byte accept to DONE entry when in_valid is held high.

Reset
REQ-033 rst_n=0 at a clk1 edge SHALL force IDLE, in_ready=0, mem_we=0, busy=0, done=0, cpu_run=0, illegal_cnt=0, hlt_seen=0, indices 0, regardless of state.
REQ-034 Reset mid-load SHALL discard the partial word and issue no further writes; memory contents already written are not altered.

Verification
REQ-035 start, base=0, cnt=2, bytes 28 01 00 0A FC 00 00 00 streamed back-to-back -> writes mem[0]=0x2801000A, mem[1]=0xFC000000; done=1, cpu_run=1, hlt_seen=1, illegal_cnt=0; DONE entered 10 cycles after first accept.
REQ-036 start, base=1023, cnt=2 -> writes at addresses 1023 then 0.
REQ-037 cnt=1, word 0x18000000 (opcode 6) -> illegal_cnt=1; 300 illegal words -> illegal_cnt=255.
REQ-038 in_valid toggled randomly -> identical writes to back-to-back case, only later; no write before the fourth byte.
REQ-039 abort after 6 bytes of a 3-word load -> exactly one write, FSM IDLE, done=0; start again during busy is ignored.
REQ-040 rst_n low during COLLECT, then start, cnt=0 -> all outputs at reset values, then done=1 next cycle with no mem_we.
